// File: rtl/ppi_8255a.sv
// Mode-0 programmable peripheral interface (8255A style): ports A, B and split port C over an 8-bit host bus.
// Define PPI_BSR_EN to enable port C bit set/reset writes to the control address.
module ppi_8255a (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       nCs,
  input  logic       nRe,
  input  logic       nWr,
  input  logic [1:0] A,
  inout  wire  [7:0] PortD,
  inout  wire  [7:0] PortA,
  inout  wire  [7:0] PortB,
  inout  wire  [3:0] PortCl,
  inout  wire  [3:0] PortCu
);

  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] latA_q, latA_d;
  logic [7:0] latB_q, latB_d;
  logic [7:0] latC_q, latC_d;
  logic [7:0] inA_q, inB_q, inC_q;
  logic       wrEn, rdEn;
  logic       dirA, dirB, dirCl, dirCu;
  logic       busOe;
  logic [7:0] rdData;

  assign wrEn  = ~nCs & ~nWr &  nRe;
  assign rdEn  = ~nCs & ~nRe &  nWr;

  // Direction bits: 1 = input (pins released), 0 = output.
  assign dirA  = ctrl_q[4];
  assign dirCu = ctrl_q[3];
  assign dirB  = ctrl_q[1];
  assign dirCl = ctrl_q[0];

  always_comb begin
    ctrl_d = ctrl_q;
    latA_d = latA_q;
    latB_d = latB_q;
    latC_d = latC_q;
    if (wrEn) begin
      case (A)
        2'b00: latA_d = PortD;
        2'b01: latB_d = PortD;
        2'b10: latC_d = PortD;
        default: begin
          if (PortD[7]) begin
            // Only mode-0 words are accepted; anything else leaves all state untouched.
            if (PortD[6:5] == 2'b00 && !PortD[2]) begin
              ctrl_d = PortD;
              latA_d = 8'h00;
              latB_d = 8'h00;
              latC_d = 8'h00;
            end
          end else begin
`ifdef PPI_BSR_EN
            latC_d[PortD[3:1]] = PortD[0];
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q <= 8'h9B;
      latA_q <= 8'h00;
      latB_q <= 8'h00;
      latC_q <= 8'h00;
      inA_q  <= 8'h00;
      inB_q  <= 8'h00;
      inC_q  <= 8'h00;
    end else begin
      ctrl_q <= ctrl_d;
      latA_q <= latA_d;
      latB_q <= latB_d;
      latC_q <= latC_d;
      inA_q  <= PortA;
      inB_q  <= PortB;
      inC_q  <= {PortCu, PortCl};
    end
  end

  always_comb begin
    rdData = 8'h00;
    case (A)
      2'b00: rdData = dirA ? inA_q : latA_q;
      2'b01: rdData = dirB ? inB_q : latB_q;
      2'b10: rdData = {dirCu ? inC_q[7:4] : latC_q[7:4],
                       dirCl ? inC_q[3:0] : latC_q[3:0]};
      default: rdData = 8'h00;
    endcase
  end

  assign busOe  = rdEn & (A != 2'b11);

  assign PortD  = busOe ? rdData       : 8'hzz;
  assign PortA  = dirA  ? 8'hzz        : latA_q;
  assign PortB  = dirB  ? 8'hzz        : latB_q;
  assign PortCl = dirCl ? 4'hz         : latC_q[3:0];
  assign PortCu = dirCu ? 4'hz         : latC_q[7:4];

endmodule

// File: tb/tb_ppi_8255a.sv
// Self-checking bench for ppi_8255a: directed scenarios plus randomized bus traffic against a port-level model.
module tb_ppi_8255a;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, nCs, nRe, nWr;
  logic [1:0] A;
  wire  [7:0] PortD, PortA, PortB;
  wire  [3:0] PortCl, PortCu;

  logic [7:0] dDrv, aDrv, bDrv;
  logic [3:0] clDrv, cuDrv;
  logic       dEn, aEn, bEn, clEn, cuEn;

  assign PortD  = dEn  ? dDrv  : 8'hzz;
  assign PortA  = aEn  ? aDrv  : 8'hzz;
  assign PortB  = bEn  ? bDrv  : 8'hzz;
  assign PortCl = clEn ? clDrv : 4'hz;
  assign PortCu = cuEn ? cuDrv : 4'hz;

  ppi_8255a dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .nCs    (nCs),
    .nRe    (nRe),
    .nWr    (nWr),
    .A      (A),
    .PortD  (PortD),
    .PortA  (PortA),
    .PortB  (PortB),
    .PortCl (PortCl),
    .PortCu (PortCu)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: the control word, three output latches and three input registers (index 0=A, 1=B, 2=C).
  logic [7:0] mCtrl;
  logic [7:0] mLat [3];
  logic [7:0] mIn  [3];

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic inA();  return mCtrl[4]; endfunction
  function automatic logic inCu(); return mCtrl[3]; endfunction
  function automatic logic inB();  return mCtrl[1]; endfunction
  function automatic logic inCl(); return mCtrl[0]; endfunction

  function automatic logic [7:0] expA();
    return inA() ? aDrv : mLat[0];
  endfunction

  function automatic logic [7:0] expB();
    return inB() ? bDrv : mLat[1];
  endfunction

  function automatic logic [7:0] expC();
    return {inCu() ? cuDrv : mLat[2][7:4], inCl() ? clDrv : mLat[2][3:0]};
  endfunction

  function automatic logic [7:0] modelRead(input logic [1:0] addr);
    case (addr)
      2'd0: return inA() ? mIn[0] : mLat[0];
      2'd1: return inB() ? mIn[1] : mLat[1];
      2'd2: return {inCu() ? mIn[2][7:4] : mLat[2][7:4], inCl() ? mIn[2][3:0] : mLat[2][3:0]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    mCtrl = 8'h9B;
    for (int i = 0; i < 3; i++) begin
      mLat[i] = 8'h00;
      mIn[i]  = 8'h00;
    end
  endtask

  task automatic modelWrite(input logic [1:0] addr, input logic [7:0] data);
    logic [7:0] mask;
    mask = 8'd1 << data[3:1];
    if (addr != 2'd3) begin
      mLat[addr] = data;
    end else if (data[7]) begin
      if ((data & 8'h64) == 8'h00) begin
        mCtrl = data;
        for (int i = 0; i < 3; i++) mLat[i] = 8'h00;
      end
    end else begin
`ifdef PPI_BSR_EN
      if (data[0]) mLat[2] = mLat[2] | mask;
      else         mLat[2] = mLat[2] & ~mask;
`else
      mask = 8'h00;
`endif
    end
  endtask

  // Drive fresh random values only on pins the model says are inputs.
  task automatic refreshPins();
    aEn   = inA();
    bEn   = inB();
    clEn  = inCl();
    cuEn  = inCu();
    aDrv  = 8'($urandom);
    bDrv  = 8'($urandom);
    clDrv = 4'($urandom);
    cuDrv = 4'($urandom);
  endtask

  task automatic checkPins();
    logic [7:0] c;
    c = expC();
    checkOutput("pinA",  PortA, expA());
    checkOutput("pinB",  PortB, expB());
    checkOutput("pinCl", {4'h0, PortCl}, {4'h0, c[3:0]});
    checkOutput("pinCu", {4'h0, PortCu}, {4'h0, c[7:4]});
  endtask

  // One bus cycle: drive strobes, check pins and bus, then advance the model across the clock edge.
  task automatic applyStimulus(input logic rst, input logic cs, input logic rd, input logic wr,
                               input logic [1:0] addr, input logic [7:0] data);
    logic [7:0] pa, pb, pc;
    logic readCyc, writeCyc;
    Reset    = rst;
    nCs      = cs;
    nRe      = rd;
    nWr      = wr;
    A        = addr;
    readCyc  = !cs && !rd && wr;
    writeCyc = !cs && !wr && rd;
    dEn      = !(readCyc && addr != 2'd3);
    dDrv     = writeCyc ? data : 8'($urandom);
    #1;
    checkPins();
    if (dEn) checkOutput("busRelease", PortD, dDrv);
    else     checkOutput("busRead", PortD, modelRead(addr));
    pa = expA();
    pb = expB();
    pc = expC();
    @(posedge Clk);
    if (rst) begin
      modelReset();
    end else begin
      mIn[0] = pa;
      mIn[1] = pb;
      mIn[2] = pc;
      if (writeCyc) modelWrite(addr, data);
    end
    #1;
    refreshPins();
  endtask

  task automatic wrCycle(input logic [1:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, addr, data);
  endtask

  task automatic rdCycle(input logic [1:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, addr, 8'h00);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
  endtask

  initial begin
    logic       rst, cs, rd, wr;
    logic [1:0] addr;
    logic [7:0] data;
    int         op;

    Reset = 1'b1; nCs = 1'b0; nRe = 1'b1; nWr = 1'b0; A = 2'd3;
    dEn = 1'b1; dDrv = 8'h80;
    aEn = 1'b1; bEn = 1'b1; clEn = 1'b1; cuEn = 1'b1;
    aDrv = 8'h00; bDrv = 8'h00; clDrv = 4'h0; cuDrv = 4'h0;
    modelReset();
    repeat (2) @(posedge Clk);
    #1;
    refreshPins();

    // Right after reset, input registers still hold zero even though pins are driven.
    rdCycle(2'd0);
    rdCycle(2'd1);
    rdCycle(2'd2);
    rdCycle(2'd3);
    idleCycle();

    wrCycle(2'd3, 8'h80);
    wrCycle(2'd0, 8'h5A);
    rdCycle(2'd0);

    wrCycle(2'd3, 8'h83);
    idleCycle();
    rdCycle(2'd1);
    rdCycle(2'd2);

    // Back-to-back control words with the write strobe held.
    wrCycle(2'd0, 8'hA5);
    wrCycle(2'd3, 8'h92);
    wrCycle(2'd3, 8'h99);
    wrCycle(2'd3, 8'h9B);
    wrCycle(2'd3, 8'h9B);
    rdCycle(2'd2);

    wrCycle(2'd3, 8'h80);
    wrCycle(2'd1, 8'h3C);
    wrCycle(2'd3, 8'hC0);
    wrCycle(2'd3, 8'h84);
    rdCycle(2'd1);
    wrCycle(2'd0, 8'hFF);
    idleCycle();

    wrCycle(2'd2, 8'h00);
    wrCycle(2'd3, 8'h0F);
    idleCycle();
    wrCycle(2'd3, 8'h0E);
    wrCycle(2'd3, 8'h03);
    rdCycle(2'd2);

    // Both strobes low, and deselected write: neither may change state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h66);
    rdCycle(2'd0);
    rdCycle(2'd1);

    // Reset wins over a simultaneous write.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'hEE);
    rdCycle(2'd0);

    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 79) == 0);
      cs   = ($urandom_range(0, 5) == 0);
      op   = $urandom_range(0, 9);
      rd   = !(op inside {[0:2], 9});
      wr   = !(op inside {[3:7], 9});
      addr = 2'($urandom);
      data = 8'($urandom);
      if (addr == 2'd3 && $urandom_range(0, 1) == 1) data = 8'h80 | (data & 8'h1B);
      applyStimulus(rst, cs, rd, wr, addr, data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
